// File: rtl/ahfp_norm_if.sv
// Handshake and data bundle between the subtractor datapath and the normaliser.
// clk_en gates the whole normaliser; start/done form a multi-cycle request/complete pair.
interface ahfp_norm_if;
  logic        clk_en;
  logic        start;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic [31:0] result;
  logic        done;

  modport master (
    output clk_en, start, in_sign, in_exp, in_mant,
    input  result, done
  );

  modport slave (
    input  clk_en, start, in_sign, in_exp, in_mant,
    output result, done
  );
endinterface

// File: rtl/ahfp_norm.sv
// Multi-cycle normaliser: signed mantissa difference -> packed IEEE-754 single. Latency 2+s
// (serial) or 2/3 with AHFP_NORM_FAST_SHIFT_EN; start ignored outside IDLE, clk_en low freezes all state.
module ahfp_norm (
  input  logic        clk,
  input  logic        reset_n,
  ahfp_norm_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ABS  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_d;
  logic        sgn_q, sgn_d;
  logic [7:0]  exp_q, exp_d;
  logic [24:0] mag_q, mag_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

`ifdef AHFP_NORM_FAST_SHIFT_EN
  logic [4:0] lzc;
  logic [7:0] exp_m1;
  logic [7:0] shamt;

  // Shift is capped at exp-1 so an underflowing operand lands on exp==1 and flushes next cycle.
  always_comb begin
    lzc = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (mag_q[i]) lzc = 5'(23 - i);
    end
    exp_m1 = exp_q - 8'd1;
    shamt  = (exp_m1 < {3'd0, lzc}) ? exp_m1 : {3'd0, lzc};
  end
`endif

  always_comb begin
    state_d  = state;
    sgn_d    = sgn_q;
    exp_d    = exp_q;
    mag_d    = mag_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          sgn_d   = bus.in_sign;
          exp_d   = bus.in_exp;
          mag_d   = bus.in_mant;
          state_d = ABS;
        end
      end

      ABS: begin
        mag_d   = mag_q[24] ? (~mag_q + 25'd1) : mag_q;
        sgn_d   = sgn_q ^ mag_q[24];
        state_d = NORM;
      end

      NORM: begin
        if (mag_q == 25'd0) begin
          result_d = 32'h0000_0000;
          done_d   = 1'b1;
          state_d  = DONE;
        end else if (exp_q == 8'hFF) begin
          result_d = {sgn_q, 8'hFF, 23'h0};
          done_d   = 1'b1;
          state_d  = DONE;
        end else if (mag_q[24]) begin
          // An exponent reaching 8'hFF here is caught by the infinity rule next cycle.
          mag_d = mag_q >> 1;
          exp_d = exp_q + 8'd1;
        end else if (mag_q[23]) begin
          result_d = {sgn_q, exp_q, mag_q[22:0]};
          done_d   = 1'b1;
          state_d  = DONE;
        end else if (exp_q <= 8'd1) begin
          result_d = 32'h0000_0000;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
`ifdef AHFP_NORM_FAST_SHIFT_EN
          mag_d = mag_q << shamt[4:0];
          exp_d = exp_q - shamt;
`else
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sgn_q    <= 1'b0;
      exp_q    <= 8'd0;
      mag_q    <= 25'd0;
      result_q <= 32'h0000_0000;
      done_q   <= 1'b0;
    end else if (bus.clk_en) begin
      state    <= state_d;
      sgn_q    <= sgn_d;
      exp_q    <= exp_d;
      mag_q    <= mag_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_ahfp_norm.sv
// Self-checking bench for ahfp_norm: directed vectors, randomized operands against a value-level model,
// clk_en stalls, mid-operation reset and a held start line.
module tb_ahfp_norm;

  logic clk;
  logic reset_n;
  int   n_pass;
  int   n_total;

  ahfp_norm_if bus ();

  ahfp_norm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef AHFP_NORM_FAST_SHIFT_EN
  localparam int DEEP_LAT = 3;
`else
  localparam int DEEP_LAT = 25;
`endif

  localparam int ND = 7;
  logic        d_sign [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [7:0]  d_exp  [ND] = '{8'h80, 8'h80, 8'h5A, 8'h01, 8'h7F, 8'hFE, 8'h80};
  logic [24:0] d_mant [ND] = '{25'h0400000, 25'h1800000, 25'h0000000, 25'h0400000,
                               25'h1000000, 25'h1000000, 25'h0000001};
  logic [31:0] d_res  [ND] = '{32'h3F80_0000, 32'hC000_0000, 32'h0000_0000, 32'h0000_0000,
                               32'hC000_0000, 32'hFF80_0000, 32'h3480_0000};
  int          d_lat  [ND] = '{3, 2, 2, 2, 3, 3, DEEP_LAT};

  // Value-level reference: magnitude/sign from plain integers, exponent from the MSB position.
  function automatic void model(input logic s_in, input logic [7:0] e_in, input logic [24:0] m_in,
                                output logic [31:0] res, output int lat);
    int          mag;
    int          e;
    int          extra;
    int          p;
    int          need;
    int          sh;
    logic        sg;
    logic [7:0]  e8;
    logic [24:0] mg;
    mag   = m_in[24] ? (33554432 - int'(m_in)) : int'(m_in);
    sg    = s_in ^ m_in[24];
    e     = int'(e_in);
    extra = 0;
    if (mag == 0) begin
      res = 32'h0; lat = 2; return;
    end
    if (e == 255) begin
      res = {sg, 8'hFF, 23'h0}; lat = 2; return;
    end
    if (mag >= 16777216) begin
      mag   = mag / 2;
      e     = e + 1;
      extra = 1;
      if (e == 255) begin
        res = {sg, 8'hFF, 23'h0}; lat = 3; return;
      end
    end
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    need = 23 - p;
    if (need == 0) begin
      mg  = 25'(mag);
      e8  = 8'(e);
      res = {sg, e8, mg[22:0]};
      lat = 2 + extra;
      return;
    end
    if (e <= 1) begin
      res = 32'h0; lat = 2 + extra; return;
    end
    sh = (need < e - 1) ? need : e - 1;
`ifdef AHFP_NORM_FAST_SHIFT_EN
    lat = 3 + extra;
`else
    lat = 2 + extra + sh;
`endif
    if (sh == need) begin
      mg  = 25'(mag) << need;
      e8  = 8'(e - need);
      res = {sg, e8, mg[22:0]};
    end else begin
      res = 32'h0;
    end
  endfunction

  // Stimulus driver; call just after a falling edge. Capture is edge 0, lat counts edges until done.
  task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] m,
                        input int stall_at, input int stall_len,
                        output logic [31:0] res, output int lat, output logic done_after);
    lat        = -1;
    res        = 'x;
    done_after = 1'bx;
    bus.in_sign = s;
    bus.in_exp  = e;
    bus.in_mant = m;
    bus.start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.in_sign = 1'($urandom);
    bus.in_exp  = 8'($urandom);
    bus.in_mant = 25'($urandom);
    for (int k = 1; k <= 80; k++) begin
      bus.clk_en = (k >= stall_at && k < stall_at + stall_len) ? 1'b0 : 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        res = bus.result;
        break;
      end
    end
    bus.clk_en = 1'b1;
    if (lat >= 0) begin
      @(posedge clk);
      @(negedge clk);
      done_after = bus.done;
    end
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    bus.clk_en  = 1'b1;
    bus.start   = 1'b0;
    bus.in_sign = 1'b0;
    bus.in_exp  = 8'h0;
    bus.in_mant = 25'h0;
    repeat (2) @(negedge clk);
    n_total++;
    if (bus.result !== 32'h0) $display("FAIL reset_result: got %h want 00000000", bus.result);
    else n_pass++;
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done);
    else n_pass++;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (bus.result !== 32'h0 || bus.done !== 1'b0)
      $display("FAIL idle_after_reset: result %h done %b want 00000000 0", bus.result, bus.done);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [31:0] res;
    logic [31:0] mres;
    int          lat;
    int          mlat;
    logic        da;
    for (int i = 0; i < ND; i++) begin
      run_op(d_sign[i], d_exp[i], d_mant[i], 0, 0, res, lat, da);
      model(d_sign[i], d_exp[i], d_mant[i], mres, mlat);
      n_total++;
      if (res !== d_res[i]) $display("FAIL dir%0d_result: got %h want %h", i, res, d_res[i]);
      else n_pass++;
      n_total++;
      if (lat !== d_lat[i]) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, d_lat[i]);
      else n_pass++;
      n_total++;
      if (res !== mres || lat !== mlat)
        $display("FAIL dir%0d_model: got %h/%0d model %h/%0d", i, res, lat, mres, mlat);
      else n_pass++;
      n_total++;
      if (da !== 1'b0) $display("FAIL dir%0d_done_width: done after next edge %b want 0", i, da);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] res;
    logic [31:0] mres;
    int          lat;
    int          mlat;
    logic        da;
    logic        s;
    logic [7:0]  e;
    logic [24:0] m;
    logic [7:0]  edge_exp [6] = '{8'h00, 8'h01, 8'h02, 8'h17, 8'hFE, 8'hFF};
    for (int i = 0; i < 120; i++) begin
      s = 1'($urandom);
      e = ($urandom_range(0, 3) == 0) ? edge_exp[$urandom_range(0, 5)] : 8'($urandom);
      case ($urandom_range(0, 3))
        0: m = 25'($urandom);
        1: m = 25'd1 << $urandom_range(0, 24);
        2: m = 25'($urandom_range(0, 255));
        default: m = 25'($urandom) >> $urandom_range(0, 24);
      endcase
      if ($urandom_range(0, 1) == 1) m = -m;
      model(s, e, m, mres, mlat);
      run_op(s, e, m, 0, 0, res, lat, da);
      n_total++;
      if (res !== mres || lat !== mlat || da !== 1'b0)
        $display("FAIL rand%0d s=%b e=%h m=%h: got %h lat %0d tail %b want %h lat %0d tail 0",
                 i, s, e, m, res, lat, da, mres, mlat);
      else n_pass++;
    end
  endtask

  task automatic test_clk_en_stall();
    logic [31:0] res;
    logic [31:0] mres;
    int          lat;
    int          mlat;
    logic        da;
    model(1'b0, 8'h80, 25'h0000001, mres, mlat);
    run_op(1'b0, 8'h80, 25'h0000001, 3, 4, res, lat, da);
    n_total++;
    if (res !== mres) $display("FAIL stall_result: got %h want %h", res, mres);
    else n_pass++;
    n_total++;
    if (lat !== mlat + 4) $display("FAIL stall_latency: got %0d want %0d", lat, mlat + 4);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    logic [31:0] mres;
    int          lat;
    int          mlat;
    logic        da;
    int          dones;
    bus.in_sign = 1'b0;
    bus.in_exp  = 8'h80;
    bus.in_mant = 25'h0000001;
    bus.start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    n_total++;
    if (bus.done !== 1'b0 || bus.result !== 32'h0)
      $display("FAIL midop_reset: done %b result %h want 0 00000000", bus.done, bus.result);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_total++;
    if (dones !== 0 || bus.result !== 32'h0)
      $display("FAIL midop_discard: dones %0d result %h want 0 00000000", dones, bus.result);
    else n_pass++;
    model(1'b1, 8'h90, 25'h0003ABC, mres, mlat);
    run_op(1'b1, 8'h90, 25'h0003ABC, 0, 0, res, lat, da);
    n_total++;
    if (res !== mres || lat !== mlat)
      $display("FAIL midop_recover: got %h lat %0d want %h lat %0d", res, lat, mres, mlat);
    else n_pass++;
  endtask

  task automatic test_start_held();
    logic [31:0] mres;
    int          mlat;
    int          period;
    int          dones;
    int          want;
    model(1'b0, 8'h80, 25'h0800000, mres, mlat);
    period = mlat + 2;
    want   = (10 + period - 1) / period;
    dones  = 0;
    bus.in_sign = 1'b0;
    bus.in_exp  = 8'h80;
    bus.in_mant = 25'h0800000;
    bus.start   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) dones++;
    end
    bus.start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_total++;
    if (dones !== want) $display("FAIL start_held_pulses: got %0d want %0d", dones, want);
    else n_pass++;
    n_total++;
    if (bus.result !== mres) $display("FAIL start_held_result: got %h want %h", bus.result, mres);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_directed();
    test_clk_en_stall();
    test_reset_mid_op();
    test_start_held();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
